// File: rtl/led_pattern_arbiter_if.sv
// Request/pattern bundle between the LED pattern producers and the arbiter.
// The producers drive the master side and the arbiter sits on the slave side.
interface led_pattern_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int PAT_W = 32
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*PAT_W-1:0] pattern_in;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   done;
  logic [IW-1:0]          done_id;
  logic                   led;

  modport master (
    output req, pattern_in,
    input  grant, busy, done, done_id, led
  );

  modport slave (
    input  req, pattern_in,
    output grant, busy, done, done_id, led
  );
endinterface

// File: rtl/led_pattern_arbiter.sv
// Round-robin arbiter that gives the single user LED to one pattern source at a time
// and plays its latched pattern LSB first, one bit per TICK_DIV clocks, then a dark gap.
module led_pattern_arbiter #(
  parameter int N_REQ    = 3,
  parameter int PAT_W    = 32,
  parameter int TICK_DIV = 2097152
) (
  input  logic CLK,
  input  logic RST,
  led_pattern_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(PAT_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PAT_W - 1);
  localparam logic [IW-1:0] PTR_RST   = IW'(N_REQ - 1);

  logic [1:0]       state;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_idx;
  logic [IW-1:0]    last;
  logic [PAT_W-1:0] pat_sr;

  logic [N_REQ-1:0] grant_r;
  logic             busy_r;
  logic             done_r;
  logic [IW-1:0]    done_id_r;
  logic             led_r;

  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;
  logic [PAT_W-1:0] win_pat;
  logic             tick_wrap;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last) + i) % N_REQ);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    win_pat = bus.pattern_in[int'(win_idx)*PAT_W +: PAT_W];
  end

  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      last      <= PTR_RST;
      grant_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= '0;
      led_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            state    <= S_PLAY;
            tick_cnt <= '0;
            bit_idx  <= '0;
            last     <= win_idx;
            grant_r  <= N_REQ'(1) << win_idx;
            busy_r   <= 1'b1;
            led_r    <= win_pat[0];
          end
        end
        S_PLAY: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state     <= S_GAP;
              bit_idx   <= '0;
              grant_r   <= '0;
              led_r     <= 1'b0;
              done_r    <= 1'b1;
              done_id_r <= last;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              led_r   <= pat_sr[1];
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            state    <= S_IDLE;
            busy_r   <= 1'b0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pattern shift register: loaded only in the grant cycle, advanced on each bit boundary.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && win_vld) begin
      pat_sr <= win_pat;
    end else if (state == S_PLAY && tick_wrap) begin
      pat_sr <= pat_sr >> 1;
    end
  end

  assign bus.grant   = grant_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;
  assign bus.led     = led_r;
endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Bench for led_pattern_arbiter: two instances (TICK_DIV 4 and 1) share stimulus and are
// compared every cycle against a timeline model of the playback schedule.
module tb_led_pattern_arbiter;
  localparam int N  = 3;
  localparam int PW = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  req_d;
  logic [23:0] pat_d;

  always #5 CLK = ~CLK;

  led_pattern_arbiter_if #(.N_REQ(N), .PAT_W(PW)) bus4 ();
  led_pattern_arbiter_if #(.N_REQ(N), .PAT_W(PW)) bus1 ();

  assign bus4.req        = req_d;
  assign bus4.pattern_in = pat_d;
  assign bus1.req        = req_d;
  assign bus1.pattern_in = pat_d;

  led_pattern_arbiter #(.N_REQ(N), .PAT_W(PW), .TICK_DIV(4)) dut4 (
    .CLK(CLK), .RST(RST), .bus(bus4)
  );
  led_pattern_arbiter #(.N_REQ(N), .PAT_W(PW), .TICK_DIV(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1)
  );

  // Model: a playback is just "cycles elapsed since grant"; outputs follow from that count.
  int       md[2] = '{4, 1};
  bit       m_act[2];
  int       m_pos[2];
  int       m_win[2];
  logic [7:0] m_pat[2];
  int       m_last[2];
  int       m_did[2];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic model_step(input int m);
    int c;
    if (RST) begin
      m_act[m]  = 1'b0;
      m_pos[m]  = 0;
      m_last[m] = N - 1;
      m_did[m]  = 0;
    end else if (!m_act[m]) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last[m] + i) % N;
        if (req_d[c]) begin
          m_act[m]  = 1'b1;
          m_pos[m]  = 0;
          m_win[m]  = c;
          m_pat[m]  = pat_d[c*PW +: PW];
          m_last[m] = c;
          break;
        end
      end
    end else begin
      m_pos[m]++;
      if (m_pos[m] == (PW + 1) * md[m]) m_act[m] = 1'b0;
    end
    if (m_act[m] && m_pos[m] == PW * md[m]) m_did[m] = m_win[m];
  endtask

  function automatic logic [2:0] e_grant(input int m);
    if (m_act[m] && m_pos[m] < PW * md[m]) return 3'(1 << m_win[m]);
    return 3'b000;
  endfunction

  function automatic logic e_led(input int m);
    if (m_act[m] && m_pos[m] < PW * md[m]) return m_pat[m][m_pos[m] / md[m]];
    return 1'b0;
  endfunction

  function automatic logic e_done(input int m);
    return m_act[m] && (m_pos[m] == PW * md[m]);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    model_step(0);
    model_step(1);
    chk("grant_d4",   32'(bus4.grant),   32'(e_grant(0)));
    chk("led_d4",     32'(bus4.led),     32'(e_led(0)));
    chk("busy_d4",    32'(bus4.busy),    32'(m_act[0]));
    chk("done_d4",    32'(bus4.done),    32'(e_done(0)));
    chk("done_id_d4", 32'(bus4.done_id), 32'(m_did[0]));
    chk("grant_d1",   32'(bus1.grant),   32'(e_grant(1)));
    chk("led_d1",     32'(bus1.led),     32'(e_led(1)));
    chk("busy_d1",    32'(bus1.busy),    32'(m_act[1]));
    chk("done_d1",    32'(bus1.done),    32'(e_done(1)));
    chk("done_id_d1", 32'(bus1.done_id), 32'(m_did[1]));
  endtask

  initial begin
    logic [7:0]  seq;
    logic [2:0]  prev;
    logic [2:0]  exp_order[4];
    int          gstart[$];
    logic [2:0]  gval[$];
    int          k, dcount, ones, dpos;
    logic        bsy8, bsy9;

    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    RST   = 1'b1;
    req_d = 3'b000;
    pat_d = 24'($urandom);
    tick();
    tick();
    chk("rst_grant", 32'(bus4.grant), 32'h0);
    chk("rst_busy",  32'(bus4.busy),  32'h0);
    RST = 1'b0;

    // Single request, pattern A5
    pat_d[7:0] = 8'hA5;
    req_d = 3'b001;
    tick();
    req_d = 3'b000;
    seq = '0;
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 0) seq[i/4] = bus4.led;
      tick();
    end
    chk("s1_led_seq", 32'(seq), 32'hA5);
    chk("s1_done",    32'(bus4.done), 32'h1);
    chk("s1_done_id", 32'(bus4.done_id), 32'h0);
    repeat (4) tick();
    chk("s1_idle_busy", 32'(bus4.busy), 32'h0);

    // Round-robin with all requests held
    RST = 1'b1;
    tick();
    RST = 1'b0;
    req_d = 3'b111;
    prev = 3'b000;
    repeat (4 * 37) begin
      tick();
      if (prev == 3'b000 && bus4.grant != 3'b000) begin
        gstart.push_back(cyc);
        gval.push_back(bus4.grant);
      end
      prev = bus4.grant;
    end
    chk("s2_ngrants", 32'(gstart.size()), 32'd4);
    for (int i = 0; i < 4 && i < gstart.size(); i++) begin
      chk("s2_order", 32'(gval[i]), 32'(exp_order[i]));
      if (i > 0) chk("s2_spacing", 32'(gstart[i] - gstart[i-1]), 32'd37);
    end
    req_d = 3'b000;
    repeat (40) tick();

    // Late request and pattern change during playback
    pat_d[7:0] = 8'h3C;
    req_d = 3'b001;
    tick();
    seq = '0;
    k = 0;
    while (bus4.grant !== 3'b100 && k < 80) begin
      if (k < 32 && k % 4 == 0) seq[k/4] = bus4.led;
      if (k == 6) begin
        req_d = 3'b100;
        pat_d[7:0] = 8'hC3;
      end
      tick();
      k++;
    end
    chk("s3_latched_pat", 32'(seq), 32'h3C);
    chk("s3_late_grant_delay", 32'(k), 32'd37);
    req_d = 3'b000;
    repeat (40) tick();

    // Request dropped after grant
    req_d = 3'b010;
    tick();
    chk("s4_grant", 32'(bus4.grant), 32'b010);
    req_d = 3'b000;
    repeat (32) tick();
    chk("s4_done",    32'(bus4.done), 32'h1);
    chk("s4_done_id", 32'(bus4.done_id), 32'h1);
    repeat (5) tick();

    // Reset at bit 3 of a playback
    req_d = 3'b001;
    tick();
    req_d = 3'b000;
    repeat (12) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("s5_grant", 32'(bus4.grant), 32'h0);
    chk("s5_led",   32'(bus4.led),   32'h0);
    chk("s5_busy",  32'(bus4.busy),  32'h0);
    req_d = 3'b110;
    tick();
    chk("s5_ptr_reset_grant", 32'(bus4.grant), 32'b010);
    req_d = 3'b000;
    dcount = 0;
    repeat (40) begin
      tick();
      if (bus4.done) begin
        dcount++;
        chk("s5_done_id", 32'(bus4.done_id), 32'h1);
      end
    end
    chk("s5_done_count", 32'(dcount), 32'd1);

    // TICK_DIV=1 instance, pattern FF
    RST = 1'b1;
    tick();
    RST = 1'b0;
    pat_d[7:0] = 8'hFF;
    req_d = 3'b001;
    tick();
    req_d = 3'b000;
    ones = 0;
    dpos = -1;
    bsy8 = 1'b0;
    bsy9 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus1.led) ones++;
      if (bus1.done && dpos < 0) dpos = i;
      if (i == 8) bsy8 = bus1.busy;
      if (i == 9) bsy9 = bus1.busy;
      tick();
    end
    chk("s6_led_ones", 32'(ones), 32'd8);
    chk("s6_done_pos", 32'(dpos), 32'd8);
    chk("s6_gap_busy", 32'(bsy8), 32'h1);
    chk("s6_idle_after_gap", 32'(bsy9), 32'h0);

    // Randomized traffic with occasional resets
    repeat (1500) begin
      req_d = 3'($urandom);
      if ($urandom_range(0, 3) == 0) pat_d = 24'($urandom);
      RST = ($urandom_range(0, 199) == 0);
      tick();
    end
    RST = 1'b0;
    req_d = 3'b000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/led_pattern_arbiter.md
# led_pattern_arbiter

Shares the board's single user LED between several pattern sources on the TinyFPGA BX. Each requester asks to play a fixed-width blink pattern. The arbiter grants requesters round-robin, latches the granted pattern and shifts it onto the LED one bit per tick. Ticks come from a 16 MHz-derived divider, and each playback ends with a done pulse and a dark gap. The block sits between the pattern producers in `top` and the `LED` output pin.

## Interface
- `N_REQ`, default 3: number of requesters, ≥1.
- `PAT_W`, default 32: pattern length in bits, ≥2.
- `TICK_DIV`, default 2097152: CLK cycles per pattern bit (≈131 ms at 16 MHz), ≥1.

- `CLK` in 1: 16 MHz system clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `req` in N_REQ: level request per requester. The requester holds it until it sees its grant bit.
- `pattern_in` in N_REQ*PAT_W: requester i's pattern occupies bits [i*PAT_W +: PAT_W].
- `grant` out N_REQ: one-hot while playing; all zeros otherwise.
- `busy` out 1: high in PLAY and GAP.
- `done` out 1: one-cycle pulse when a playback completes.
- `done_id` out clog2(N_REQ) (min 1): index of the finished requester. Valid only while `done`=1; holds its last value otherwise.
- `led` out 1: LED drive.

## Operation
- States: IDLE, PLAY, GAP.
- **IDLE**
  - `led`=0 and `grant`=0.
  - If `req`≠0, select the winner by round-robin. The search starts at `last`+1 and wraps mod N_REQ.
  - Latch the winner's `pattern_in` slice into the shift register, clear the tick counter and bit index, set `last`=winner, then go to PLAY.
- **PLAY**
  - `grant`=onehot(winner) and `led`=pat[bit_idx].
  - Bit order is LSB first: bit 0 plays first.
  - The tick counter counts 0..TICK_DIV-1. On the wrap, bit_idx increments.
  - On the wrap with bit_idx=PAT_W-1, go to GAP and pulse `done` with `done_id`=winner.
- **GAP**
  - `led`=0, `grant`=0, `busy`=1.
  - Lasts exactly TICK_DIV cycles, then returns to IDLE.
- Patterns are latched only in the grant cycle. Later changes to `pattern_in` or `req` do not affect the playback in progress.
- Dropping `req` mid-playback does not abort it; `done` still pulses.
- Requests that arrive during PLAY or GAP wait. They are arbitrated on the next IDLE cycle.
- The round-robin pointer `last` resets to N_REQ-1, so requester 0 wins first after reset.
- Width rules:
  - The tick counter is clog2(TICK_DIV) bits, min 1.
  - bit_idx is clog2(PAT_W) bits.
  - No counter may overflow past its terminal value; both wrap to 0 explicitly.
- TICK_DIV=1: each bit lasts one cycle and GAP lasts one cycle.
- **Reset values:** state=IDLE, `grant`=0, `busy`=0, `done`=0, `done_id`=0, `led`=0, `last`=N_REQ-1, counters=0.
- **Reset mid-PLAY or mid-GAP:** the next cycle is IDLE with all outputs at reset values. No `done` pulse is produced for the aborted playback.

## Timing
- Let D=TICK_DIV and let `req` be first sampled nonzero in IDLE at cycle t.
- Cycle t+1: `grant`, `busy` and `led`=pat[0] are valid. Request-to-LED latency is 1 cycle.
- Bit k is shown on cycles t+1+k·D through t+(k+1)·D.
- `grant` stays high for exactly PAT_W·D cycles.
- Cycle t+PAT_W·D+1:
  - state is GAP with `grant`=0 and `led`=0;
  - `done`=1 for this cycle only.
- GAP covers cycles t+PAT_W·D+1 through t+(PAT_W+1)·D.
- IDLE is at cycle t+(PAT_W+1)·D+1. A pending request is granted in the following cycle.
- Minimum request-to-request grant spacing is (PAT_W+1)·D+1 cycles.
- All outputs are registered; there are no combinational paths from `req` or `pattern_in` to outputs.

## Test plan
Bench parameters: N_REQ=3, PAT_W=8, D=4.

1. **Single request.**
   - Stimulus: reset, then `req`=001 with pattern0=8'hA5.
   - Required: `grant`=001 from the next cycle for 32 cycles; `led` sequence 1,0,1,0,0,1,0,1 with each bit held 4 cycles; `done`=1 with `done_id`=0 for one cycle; `led`=0 for 4 GAP cycles; then IDLE.
2. **Round-robin.**
   - Stimulus: `req`=111 held throughout.
   - Required: grants in order 001, 010, 100, 001; each grant starts 37 cycles after the previous.
3. **Late request and pattern changes.**
   - Stimulus: during requester 0's playback, raise `req`[2] and change pattern0.
   - Required: requester 0 still plays its latched pattern; requester 2 is granted in the cycle after IDLE is reached.
4. **Request dropped.**
   - Stimulus: `req`[1] is dropped after its grant.
   - Required: the full 8-bit playback completes and `done_id`=1.
5. **Reset mid-PLAY.**
   - Stimulus: assert `RST` at bit 3 of a playback.
   - Required: next cycle `grant`=0, `led`=0, `busy`=0; no `done` pulse; the next `req`=110 grants requester 1 (pointer was reset).
6. **D=1 edge case.**
   - Stimulus: rerun scenario 1 with D=1 and pattern 8'hFF.
   - Required: `led`=1 for exactly 8 cycles; `done` on the 9th cycle after the grant; 1 GAP cycle.
